// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared debounce state encoding and tick polarity constants
package input_cond_pkg;

  localparam logic [1:0] ST_ZERO  = 2'b00;
  localparam logic [1:0] ST_WAIT1 = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_WAIT0 = 2'b11;

  // Downstream control FSMs test ticks against these rather than literals.
  localparam logic TICK_ON  = 1'b1;
  localparam logic TICK_OFF = 1'b0;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } ch_out_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: 2-FF synchroniser, debounce FSM, timer, registered outputs
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic rise_tick,
  output logic fall_tick,
  output logic tick_next
);

  localparam logic [CNT_W-1:0] T_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1, s;
  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] t, t_nxt;
  ch_out_t          q, q_nxt;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    q_nxt     = '{level: q.level, rise: TICK_OFF, fall: TICK_OFF};
    case (state)
      ST_ZERO: begin
        if (s) begin
          state_nxt = ST_WAIT1;
          t_nxt     = '0;
        end
      end
      ST_WAIT1: begin
        if (!s) begin
          state_nxt = ST_ZERO;
          t_nxt     = '0;
        end else if (t == T_LAST) begin
          state_nxt   = ST_ONE;
          t_nxt       = '0;
          q_nxt.level = 1'b1;
          q_nxt.rise  = TICK_ON;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      ST_ONE: begin
        if (!s) begin
          state_nxt = ST_WAIT0;
          t_nxt     = '0;
        end
      end
      ST_WAIT0: begin
        if (s) begin
          state_nxt = ST_ONE;
          t_nxt     = '0;
        end else if (t == T_LAST) begin
          state_nxt   = ST_ZERO;
          t_nxt       = '0;
          q_nxt.level = 1'b0;
          q_nxt.fall  = TICK_ON;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
    endcase
  end

  // Exposed so the top can register any_tick on the same edge as the ticks.
  assign tick_next = q_nxt.rise | q_nxt.fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= ST_ZERO;
      t     <= '0;
      q     <= '{level: 1'b0, rise: TICK_OFF, fall: TICK_OFF};
    end else begin
      s1    <= raw_in;
      s     <= s1;
      state <= state_nxt;
      t     <= t_nxt;
      q     <= q_nxt;
    end
  end

  assign level     = q.level;
  assign rise_tick = q.rise;
  assign fall_tick = q.fall;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - N_CH debounced inputs with rise/fall ticks and a combined any_tick
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DB_CYCLES = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise_tick,
  output logic [N_CH-1:0] fall_tick,
  output logic            any_tick
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [N_CH-1:0] tick_next;

  genvar ch;
  generate
    for (ch = 0; ch < N_CH; ch++) begin : g_ch
      debounce_channel #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in[ch]),
        .level    (level[ch]),
        .rise_tick(rise_tick[ch]),
        .fall_tick(fall_tick[ch]),
        .tick_next(tick_next[ch])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) any_tick <= TICK_OFF;
    else       any_tick <= |tick_next;
  end

endmodule
